// File: rtl/div_seq_if.sv
// div_seq_if: request/result handshake and shared-ALU hookup between the EXU and the divide sequencer
interface div_seq_if #(
  parameter int WIDTH     = 32,
  parameter int OPT_WIDTH = 4
);
  logic                 i_valid;
  logic                 o_ready;
  logic [1:0]           i_op;
  logic [WIDTH-1:0]     i_src1;
  logic [WIDTH-1:0]     i_src2;
  logic                 i_flush;
  logic                 o_valid;
  logic                 i_ready;
  logic [WIDTH-1:0]     o_res;
  logic [WIDTH-1:0]     o_alu_src1;
  logic [WIDTH-1:0]     o_alu_src2;
  logic [OPT_WIDTH-1:0] o_alu_opt;
  logic [WIDTH-1:0]     i_alu_res;
  logic                 i_alu_sububit;
  modport slave (
    input  i_valid, i_op, i_src1, i_src2, i_flush, i_ready, i_alu_res, i_alu_sububit,
    output o_ready, o_valid, o_res, o_alu_src1, o_alu_src2, o_alu_opt
  );
  modport master (
    output i_valid, i_op, i_src1, i_src2, i_flush, i_ready, i_alu_res, i_alu_sububit,
    input  o_ready, o_valid, o_res, o_alu_src1, o_alu_src2, o_alu_opt
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU/REM/REMU using one shared-ALU subtraction per cycle
module div_seq #(
  parameter int                   WIDTH     = 32,
  parameter int                   OPT_WIDTH = 4,
  parameter logic [OPT_WIDTH-1:0] ALU_SUBU  = OPT_WIDTH'(1)
) (
  input logic      i_clk,
  input logic      i_rst_n,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dsr_q, dsr_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             negq_q, negq_d, negr_q, negr_d, valid_q, valid_d, ready_q, ready_d;
  logic [WIDTH-1:0] trial, abs1, abs2;
  logic             sgn, accept, div0, ovf;
  // operand magnitudes, special-case detection and the shifted trial dividend
  always_comb begin
    sgn    = ~bus.i_op[0];
    abs1   = (sgn && bus.i_src1[WIDTH-1]) ? -bus.i_src1 : bus.i_src1;
    abs2   = (sgn && bus.i_src2[WIDTH-1]) ? -bus.i_src2 : bus.i_src2;
    div0   = bus.i_src2 == '0;
    ovf    = sgn && (bus.i_src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.i_src2);
    accept = (state_q == IDLE) && bus.i_valid && ready_q && !bus.i_flush;
    trial  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
  end
  // next-state and datapath updates; flush overrides everything
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsr_d   = dsr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    valid_d = valid_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = bus.i_op;
        negq_d  = sgn && (bus.i_src1[WIDTH-1] ^ bus.i_src2[WIDTH-1]);
        negr_d  = sgn && bus.i_src1[WIDTH-1];
        quot_d  = abs1;
        dsr_d   = abs2;
        rem_d   = '0;
        cnt_d   = '0;
        ready_d = 1'b0;
        state_d = (div0 || ovf) ? DONE : CALC;
        valid_d = div0 || ovf;
        res_d   = div0 ? (bus.i_op[1] ? bus.i_src1 : '1) : ovf ? (bus.i_op[1] ? '0 : bus.i_src1) : res_q;
      end
      CALC: begin
        rem_d   = bus.i_alu_sububit ? trial : bus.i_alu_res;
        quot_d  = {quot_q[WIDTH-2:0], ~bus.i_alu_sububit};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
      end
      FIX: begin
        res_d   = op_q[1] ? (negr_q ? -rem_q : rem_q) : (negq_q ? -quot_q : quot_q);
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.i_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ready_d = 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quot_q  <= '0;
      dsr_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dsr_q   <= dsr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end
  // ALU is driven only during iterations; quiet zeros otherwise so the EXU mux sees a clean value
  always_comb begin
    bus.o_alu_src1 = (state_q == CALC) ? trial : '0;
    bus.o_alu_src2 = (state_q == CALC) ? dsr_q : '0;
    bus.o_alu_opt  = ALU_SUBU;
    bus.o_ready    = ready_q;
    bus.o_valid    = valid_q;
    bus.o_res      = res_q;
  end
endmodule
